// File: rtl/iterative_alu.sv
// iterative_alu: multi-cycle ALU with optional RV32M multiply/divide (enabled by ALU_MDU_EN)
module iterative_alu #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [4:0]      ctrl_in,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            ready,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);
`ifdef ALU_MDU_EN
  typedef enum logic [1:0] {IDLE, FIN, MUL, DIV} state_t;
`else
  typedef enum logic {IDLE, FIN} state_t;
`endif
  state_t          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d, alu_r, fin_r;
  logic            zero_q, zero_d, illegal_q, illegal_d, alu_ill, fin, fin_ill;
  logic [SHW-1:0]  shamt;
  assign shamt = b[SHW-1:0];
  // single-cycle operations evaluated straight from the live inputs
  always_comb begin
    alu_ill = 1'b0;
    case (ctrl_in)
      5'b00000: alu_r = a & b;
      5'b00001: alu_r = a | b;
      5'b00010: alu_r = a + b;
      5'b00011: alu_r = a ^ b;
      5'b00100: alu_r = a << shamt;
      5'b00101: alu_r = a >> shamt;
      5'b00110: alu_r = a - b;
      5'b00111: alu_r = $signed(a) >>> shamt;
      5'b01000: alu_r = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      5'b01001: alu_r = {{(XLEN-1){1'b0}}, a < b};
      default: begin
        alu_r   = '0;
        alu_ill = 1'b1;
      end
    endcase
  end
`ifdef ALU_MDU_EN
  // prod_q holds {hi, lo}: for MUL {partial product, remaining multiplier}, for DIV {remainder, quotient}
  logic [2*XLEN-1:0] prod_q, prod_d, mul_nxt, div_nxt, mul_p;
  logic [XLEN-1:0]   m_q, m_d, ma, mb, div_q, div_r, special_r;
  logic [SHW-1:0]    cnt_q, cnt_d;
  logic [1:0]        op_q, op_d;
  logic              neg_q, neg_d, rneg_q, rneg_d, sa, sb, na, nb, mdu, bz, ovf;
  logic [XLEN:0]     mul_sum, div_sh, div_diff;
  logic [2*XLEN:0]   mul_w;
  assign mdu       = ctrl_in[4:3] == 2'b10;
  assign bz        = b == '0;
  assign ovf       = !ctrl_in[0] && a == {1'b1, {(XLEN-1){1'b0}}} && &b;
  assign special_r = bz ? (ctrl_in[1] ? a : '1) : (ctrl_in[1] ? '0 : a);
  assign sa        = ctrl_in[2] ? !ctrl_in[0] : ctrl_in[1:0] != 2'b11;
  assign sb        = ctrl_in[2] ? !ctrl_in[0] : !ctrl_in[1];
  assign na        = sa && a[XLEN-1];
  assign nb        = sb && b[XLEN-1];
  assign ma        = na ? -a : a;
  assign mb        = nb ? -b : b;
  assign mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, m_q} : '0);
  assign mul_w     = {mul_sum, prod_q[XLEN-1:0]};
  assign mul_nxt   = mul_w[2*XLEN:1];
  assign mul_p     = neg_q ? -mul_nxt : mul_nxt;
  assign div_sh    = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]};
  assign div_diff  = div_sh - {1'b0, m_q};
  assign div_nxt   = div_diff[XLEN] ? {div_sh[XLEN-1:0], prod_q[XLEN-2:0], 1'b0}
                                    : {div_diff[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
  assign div_q     = neg_q ? -div_nxt[XLEN-1:0] : div_nxt[XLEN-1:0];
  assign div_r     = rneg_q ? -div_nxt[2*XLEN-1:XLEN] : div_nxt[2*XLEN-1:XLEN];
`endif
  // next-state logic; results are captured on the edge that enters FIN
  always_comb begin
    state_d   = state_q;
    fin       = 1'b0;
    fin_r     = '0;
    fin_ill   = 1'b0;
`ifdef ALU_MDU_EN
    prod_d    = prod_q;
    m_d       = m_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    neg_d     = neg_q;
    rneg_d    = rneg_q;
`endif
    case (state_q)
      IDLE: if (start) begin
`ifdef ALU_MDU_EN
        if (mdu && !(ctrl_in[2] && (bz || ovf))) begin
          state_d = ctrl_in[2] ? DIV : MUL;
          op_d    = ctrl_in[1:0];
          cnt_d   = SHW'(XLEN-1);
          prod_d  = {{XLEN{1'b0}}, ctrl_in[2] ? ma : mb};
          m_d     = ctrl_in[2] ? mb : ma;
          neg_d   = na ^ nb;
          rneg_d  = na;
        end else begin
          state_d = FIN;
          fin     = 1'b1;
          fin_r   = mdu ? special_r : alu_r;
          fin_ill = mdu ? 1'b0 : alu_ill;
        end
`else
        state_d = FIN;
        fin     = 1'b1;
        fin_r   = alu_r;
        fin_ill = alu_ill;
`endif
      end
`ifdef ALU_MDU_EN
      MUL: begin
        prod_d = mul_nxt;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = FIN;
          fin     = 1'b1;
          fin_r   = op_q == 2'b00 ? mul_p[XLEN-1:0] : mul_p[2*XLEN-1:XLEN];
        end
      end
      DIV: begin
        prod_d = div_nxt;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = FIN;
          fin     = 1'b1;
          fin_r   = op_q[1] ? div_r : div_q;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    result_d  = fin ? fin_r : result_q;
    zero_d    = fin ? fin_r == '0 : zero_q;
    illegal_d = fin ? fin_ill : illegal_q;
  end
  // state and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      result_q  <= '0;
      zero_q    <= 1'b1;
      illegal_q <= 1'b0;
`ifdef ALU_MDU_EN
      prod_q    <= '0;
      m_q       <= '0;
      cnt_q     <= '0;
      op_q      <= '0;
      neg_q     <= 1'b0;
      rneg_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
`ifdef ALU_MDU_EN
      prod_q    <= prod_d;
      m_q       <= m_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      neg_q     <= neg_d;
      rneg_q    <= rneg_d;
`endif
    end
  end
  assign ready   = state_q == IDLE;
  assign done    = state_q == FIN;
  assign result  = result_q;
  assign zero    = zero_q;
  assign illegal = illegal_q;
endmodule

// File: tb/tb_iterative_alu.sv
// tb_iterative_alu: directed self-checking bench for iterative_alu
module tb_iterative_alu;
  localparam int XLEN = 32;
  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic [4:0]      ctrl_in = '0;
  logic [XLEN-1:0] a = '0;
  logic [XLEN-1:0] b = '0;
  logic            ready, done, zero, illegal;
  logic [XLEN-1:0] result;
  int checks = 0;
  int errors = 0;

  iterative_alu #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .start(start), .ctrl_in(ctrl_in), .a(a), .b(b),
    .ready(ready), .done(done), .result(result), .zero(zero), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input string tag, input logic [4:0] op, input logic [XLEN-1:0] av,
                     input logic [XLEN-1:0] bv, input logic [XLEN-1:0] exp_r,
                     input logic exp_ill, input int exp_lat);
    int lat;
    check({tag, " ready_before"}, XLEN'(ready), 1);
    ctrl_in = op;
    a = av;
    b = bv;
    start = 1'b1;
    tick();
    start = 1'b0;
    a = ~av;
    b = ~bv;
    lat = 1;
    if (!done) check({tag, " ready_busy"}, XLEN'(ready), 0);
    while (!done && lat < 100) begin
      tick();
      lat++;
    end
    check({tag, " latency"}, XLEN'(lat), XLEN'(exp_lat));
    check({tag, " result"}, result, exp_r);
    check({tag, " zero"}, XLEN'(zero), XLEN'(exp_r == '0));
    check({tag, " illegal"}, XLEN'(illegal), XLEN'(exp_ill));
    check({tag, " ready_done"}, XLEN'(ready), 0);
    tick();
    check({tag, " done_once"}, XLEN'(done), 0);
  endtask

  initial begin
    int lat;
    int dones;
    tick();
    tick();
    check("rst ready", XLEN'(ready), 1);
    check("rst done", XLEN'(done), 0);
    check("rst result", result, 0);
    check("rst zero", XLEN'(zero), 1);
    check("rst illegal", XLEN'(illegal), 0);
    reset = 1'b0;
    tick();

    run("ADD", 5'b00010, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1);
    run("SUB", 5'b00110, 32'd5, 32'd5, 32'h0, 1'b0, 1);
    run("SRA", 5'b00111, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1'b0, 1);
    run("SLT", 5'b01000, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1);
    run("SLTU", 5'b01001, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1);
    run("AND", 5'b00000, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1);
    run("OR", 5'b00001, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 1'b0, 1);
    run("XOR", 5'b00011, 32'h0000_FF00, 32'h0000_0FF0, 32'h0000_F0F0, 1'b0, 1);
    run("SLL", 5'b00100, 32'h1, 32'h23, 32'h8, 1'b0, 1);
    run("SRL", 5'b00101, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0, 1);
    run("ILL11111", 5'b11111, 32'h1234, 32'h5678, 32'h0, 1'b1, 1);
    run("ADD after ill", 5'b00010, 32'd2, 32'd3, 32'd5, 1'b0, 1);
    run("ILL01010", 5'b01010, 32'h1, 32'h1, 32'h0, 1'b1, 1);

`ifdef ALU_MDU_EN
    run("MULH", 5'b10001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b0, XLEN+1);
    run("MULHU", 5'b10011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, XLEN+1);
    run("MUL", 5'b10000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, XLEN+1);
    run("MULHSU", 5'b10010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, XLEN+1);
    run("DIV", 5'b10100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, XLEN+1);
    run("REM", 5'b10110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, XLEN+1);
    run("DIVU", 5'b10101, 32'd100, 32'd7, 32'd14, 1'b0, XLEN+1);
    run("REMU", 5'b10111, 32'd100, 32'd7, 32'd2, 1'b0, XLEN+1);
    run("DIVU/0", 5'b10101, 32'd9, 32'd0, 32'hFFFF_FFFF, 1'b0, 1);
    run("REMU/0", 5'b10111, 32'd9, 32'd0, 32'd9, 1'b0, 1);
    run("DIV/0", 5'b10100, 32'd7, 32'd0, 32'hFFFF_FFFF, 1'b0, 1);
    run("DIV ovf", 5'b10100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1);
    run("REM ovf", 5'b10110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b0, 1);

    ctrl_in = 5'b10100;
    a = 32'd100;
    b = 32'hFFFF_FFF9;
    start = 1'b1;
    tick();
    ctrl_in = 5'b00010;
    lat = 1;
    dones = 0;
    while (!done && lat < 100) begin
      a = a + 32'd3;
      b = b ^ 32'h55;
      tick();
      lat++;
    end
    start = 1'b0;
    check("hs latency", XLEN'(lat), XLEN'(XLEN+1));
    check("hs result", result, 32'hFFFF_FFF2);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) dones++;
    end
    check("hs extra done", XLEN'(dones), 0);
    check("hs ready", XLEN'(ready), 1);

    run("pre-reset", 5'b00010, 32'd40, 32'd2, 32'd42, 1'b0, 1);
    ctrl_in = 5'b10000;
    a = 32'd3;
    b = 32'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    reset = 1'b1;
    #1;
`else
    run("MUL illegal", 5'b10000, 32'd7, 32'd3, 32'h0, 1'b1, 1);
    run("DIV illegal", 5'b10100, 32'd7, 32'd3, 32'h0, 1'b1, 1);
    run("pre-reset", 5'b00010, 32'd40, 32'd2, 32'd42, 1'b0, 1);
    ctrl_in = 5'b00010;
    a = 32'd3;
    b = 32'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    reset = 1'b1;
    #1;
`endif
    check("abort ready", XLEN'(ready), 1);
    check("abort done", XLEN'(done), 0);
    check("abort result", result, 0);
    check("abort zero", XLEN'(zero), 1);
    tick();
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) dones++;
    end
    check("abort no done", XLEN'(dones), 0);
    check("abort result held", result, 0);
    run("post-reset", 5'b00001, 32'h10, 32'h01, 32'h11, 1'b0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
